regfile_np_bypass: RTL and testbench

//   Parametrised multi-read-port register file for the pipelined CPU datapath. Provides one

---
 rtl/regfile_np_bypass.sv | 80 ++++++++
 tb/tb_regfile_np_bypass.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_np_bypass.sv
// Multi-read-port register file with registered outputs,
// write-to-read bypass and an optional hardwired-zero entry.
module regfile_np_bypass #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 31,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam bit            ZEN     = (ZERO_REG < DEPTH);
  localparam logic [AW-1:0] ZA      = AW'(ZERO_REG);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  function automatic logic live(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZEN && (a == ZA));
  endfunction

  assign wr_ok = wr_en && live(wr_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] q;
    logic             vq;

    assign a = rd_addr[p*AW +: AW];

    // dead or out-of-range addresses read zero; a same-cycle write wins
    always_comb begin
      v = '0;
      if (live(a)) begin
        if (wr_en && (wr_addr == a)) begin
          v = wr_data;
        end else begin
          v = mem[a];
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q  <= '0;
        vq <= 1'b0;
      end else begin
        vq <= rd_en[p];
        if (rd_en[p]) begin
          q <= v;
        end
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = q;
    assign rd_valid[p]               = vq;
  end

endmodule

// File: tb/tb_regfile_np_bypass.sv
// Directed bench for regfile_np_bypass with a reference
// model feeding an expected-result queue.
module tb_regfile_np_bypass;

  localparam int W = 64;
  localparam int N = 2;

  typedef struct {
    string        tag;
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
  } exp_t;

  logic           clk;
  logic           reset_n;
  logic           wr_en;
  logic [4:0]     wr_addr;
  logic [W-1:0]   wr_data;
  logic [N-1:0]   rd_en;
  logic [N*5-1:0] rd_addr;
  logic [N*W-1:0] rd_data;
  logic [N-1:0]   rd_valid;

  regfile_np_bypass dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  logic [W-1:0] m    [32];
  logic [W-1:0] hold [N];
  exp_t         sb   [$];

  function automatic logic [W-1:0] ref_val(
    input logic wen, input logic [4:0] wa,
    input logic [W-1:0] wd, input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (wen && wa == a) return wd;
    return m[a];
  endfunction

  task automatic check(input string tag,
                       input logic [N*W-1:0] act,
                       input logic [N*W-1:0] exp);
    ncmp++;
    assert (act === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = '0;
    for (int p = 0; p < N; p++) hold[p] = '0;
  endtask

  task automatic step(input string tag,
                      input logic wen, input logic [4:0] wa,
                      input logic [W-1:0] wd, input logic [N-1:0] ren,
                      input logic [4:0] a0, input logic [4:0] a1);
    exp_t e;
    logic [4:0] a [N];
    a[0] = a0;
    a[1] = a1;
    e.tag = tag;
    e.v   = ren;
    for (int p = 0; p < N; p++) begin
      if (ren[p]) hold[p] = ref_val(wen, wa, wd, a[p]);
      e.d[p*W +: W] = hold[p];
    end
    if (wen && wa != 5'd31) m[wa] = wd;
    sb.push_back(e);
    @(negedge clk);
    wr_en   = wen;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = ren;
    rd_addr = {a1, a0};
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".data"}, rd_data, e.d);
    check({e.tag, ".valid"}, {{(N*W-N){1'b0}}, rd_valid},
          {{(N*W-N){1'b0}}, e.v});
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por.data", rd_data, '0);
    check("por.valid", {{(N*W-N){1'b0}}, rd_valid}, '0);
    reset_n = 1'b1;

    // reset mid-run clears mem and outputs immediately
    step("rst.wr5", 1'b1, 5'd5, 64'hAA, 2'b01, 5'd5, 5'd0);
    step("rst.rd5", 1'b0, 5'd0, 64'h0, 2'b01, 5'd5, 5'd0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst.data", rd_data, '0);
    check("rst.valid", {{(N*W-N){1'b0}}, rd_valid}, '0);
    #2;
    reset_n = 1'b1;
    step("rst.after", 1'b0, 5'd0, 64'h0, 2'b01, 5'd5, 5'd0);

    step("basic.wr", 1'b1, 5'd3, 64'h1234, 2'b00, 5'd0, 5'd0);
    step("basic.rd", 1'b0, 5'd0, 64'h0, 2'b01, 5'd3, 5'd0);

    step("byp.pre", 1'b1, 5'd7, 64'h77, 2'b00, 5'd0, 5'd0);
    step("byp.same", 1'b1, 5'd7, 64'hDEAD_BEEF, 2'b11, 5'd7, 5'd7);
    step("byp.after", 1'b0, 5'd0, 64'h0, 2'b11, 5'd7, 5'd7);

    step("zero.wr", 1'b1, 5'd31, 64'hFFFF, 2'b00, 5'd0, 5'd0);
    step("zero.rd", 1'b0, 5'd0, 64'h0, 2'b11, 5'd31, 5'd31);
    step("zero.byp", 1'b1, 5'd31, 64'h1234, 2'b11, 5'd31, 5'd31);

    step("hold.wr", 1'b1, 5'd2, 64'h55, 2'b00, 5'd0, 5'd0);
    step("hold.rd", 1'b0, 5'd0, 64'h0, 2'b01, 5'd2, 5'd0);
    for (int i = 0; i < 3; i++)
      step("hold.off", 1'b1, 5'd2, 64'h66, 2'b00, 5'd2, 5'd2);
    step("hold.new", 1'b0, 5'd0, 64'h0, 2'b10, 5'd0, 5'd2);

    for (int i = 0; i < 31; i++)
      step("sweep.wr", 1'b1, 5'(i), 64'(i * 32'h0101),
           2'b00, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++)
      step("sweep.rd", 1'b0, 5'd0, 64'h0, 2'b11,
           5'(i), 5'(31 - i));

    step("wide", 1'b1, 5'd9, 64'hF00D_CAFE_8BAD_F00D, 2'b11, 5'd9, 5'd9);
    step("wide.rd", 1'b0, 5'd0, 64'h0, 2'b10, 5'd0, 5'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
